// File: rtl/pc_seq_pkg.sv
// Shared types for the PC sequencer slice.
// Jump encoding, FSM states and default vectors.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    J_NONE = 2'd0,
    J_J    = 2'd1,
    J_JR   = 2'd2,
    J_JAL  = 2'd3
  } jump_e;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_HOLD  = 2'd1,
    S_FLUSH = 2'd2
  } state_e;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;

endpackage

// File: rtl/jump_target_calc.sv
// Combinational redirect target selection.
// JR_ALIGN_CHECK_EN: misaligned JR goes to EXC_VECTOR.
module jump_target_calc
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  jump_e       jump,
  input  logic [3:0]  pc_hi,
  input  logic [25:0] jtarget,
  input  logic [31:0] jreg,
  output logic [31:0] target,
  output logic        misalign
);

`ifndef JR_ALIGN_CHECK_EN
  localparam logic [31:0] EXC_UNUSED = EXC_VECTOR;
  logic jreg_unused;
  assign jreg_unused = ^{jreg[1:0], EXC_UNUSED};
`endif

  // Pick the region-relative or register target
  always_comb begin
    target   = {pc_hi, jtarget, 2'b00};
    misalign = 1'b0;
    if (jump == J_JR) begin
`ifdef JR_ALIGN_CHECK_EN
      if (jreg[1:0] != 2'b00) begin
        target   = EXC_VECTOR;
        misalign = 1'b1;
      end else begin
        target = jreg;
      end
`else
      target = {jreg[31:2], 2'b00};
`endif
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC sequencer with stall/hold/flush FSM.
// Optional macro: JR_ALIGN_CHECK_EN.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        jvalid,
  input  logic [1:0]  jump,
  input  logic [25:0] jtarget,
  input  logic [31:0] jreg,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        flush,
  output logic        link_we,
  output logic [31:0] link_addr,
  output logic        exc_misalign,
  output logic        busy
);

  localparam logic [2:0] FC_INIT = 3'(FLUSH_CYCLES);

  state_e      state;
  logic [2:0]  cnt;
  logic [31:0] pending;
  logic [31:0] target;
  logic        misalign;
  logic        accept;
  logic        exc_q;

  assign pc_plus4  = pc + 32'd4;
  assign link_addr = pc_plus4;

  // Jumps only count while running freely
  assign accept  = (state == S_RUN) && jvalid
                && (jump != 2'd0);
  assign link_we = accept && (jump == 2'd3);

  assign flush        = (state == S_FLUSH);
  assign busy         = (state != S_RUN);
  assign exc_misalign = exc_q;

  jump_target_calc #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_calc (
    .jump     (jump_e'(jump)),
    .pc_hi    (pc_plus4[31:28]),
    .jtarget  (jtarget),
    .jreg     (jreg),
    .target   (target),
    .misalign (misalign)
  );

  // PC register, pending redirect and flush counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_VECTOR;
      state   <= S_RUN;
      cnt     <= 3'd0;
      pending <= 32'd0;
      exc_q   <= 1'b0;
    end else begin
      exc_q <= accept && misalign;
      unique case (state)
        S_RUN: begin
          if (!stall) begin
            if (accept) begin
              pc    <= target;
              cnt   <= FC_INIT;
              state <= S_FLUSH;
            end else begin
              pc <= pc_plus4;
            end
          end else if (accept) begin
            pending <= target;
            state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            pc    <= pending;
            cnt   <= FC_INIT;
            state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (!stall) begin
            pc  <= pc_plus4;
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1) state <= S_RUN;
          end
        end
        default: state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: vector table,
// corner sequences and a random reference model.
module tb_pc_sequencer;

  localparam int FC = 3;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        jvalid;
  logic [1:0]  jump;
  logic [25:0] jtarget;
  logic [31:0] jreg;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        flush;
  logic        link_we;
  logic [31:0] link_addr;
  logic        exc_misalign;
  logic        busy;

  int checks;
  int errors;

  pc_sequencer #(
    .FLUSH_CYCLES (FC)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .jvalid       (jvalid),
    .jump         (jump),
    .jtarget      (jtarget),
    .jreg         (jreg),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .flush        (flush),
    .link_we      (link_we),
    .link_addr    (link_addr),
    .exc_misalign (exc_misalign),
    .busy         (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        s;
    logic        v;
    logic [1:0]  j;
    logic [25:0] jt;
    logic [31:0] jr;
    logic [31:0] pc;
    logic        fl;
    logic        lw;
    logic        bz;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic s, input logic v,
    input logic [1:0] j, input logic [25:0] jt,
    input logic [31:0] p, input logic fl,
    input logic lw, input logic bz);
    vec_t r;
    r.s = s; r.v = v; r.j = j; r.jt = jt;
    r.jr = 32'd0; r.pc = p; r.fl = fl;
    r.lw = lw; r.bz = bz;
    return r;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h",
               name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic s, input logic v,
                       input logic [1:0] j,
                       input logic [25:0] jt,
                       input logic [31:0] jr);
    stall   = s;
    jvalid  = v;
    jump    = j;
    jtarget = jt;
    jreg    = jr;
    #1;
  endtask

  task automatic idle;
    drive(1'b0, 1'b0, 2'd0, 26'd0, 32'd0);
  endtask

  // Reference model: an architectural view of
  // pending redirect and remaining flush slots.
  logic [31:0] m_pc;
  logic        m_hold;
  logic [31:0] m_tgt;
  int          m_left;
  logic        m_exc;

  function automatic logic [31:0] ref_target(
    input logic [31:0] cur, input logic [1:0] j,
    input logic [25:0] jt, input logic [31:0] jr);
    logic [31:0] r;
    if (j == 2'd2) begin
`ifdef JR_ALIGN_CHECK_EN
      r = (jr % 4 != 0) ? 32'h0000_0180 : jr;
`else
      r = jr - (jr % 4);
`endif
    end else begin
      r = ((cur + 32'd4) & 32'hF000_0000)
        + ({6'd0, jt} * 32'd4);
    end
    return r;
  endfunction

  initial begin
    logic        acc;
    logic [31:0] t;
    logic        mis;
    logic [7:0]  sp;
    int          nfl;

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    stall  = 1'b0;
    jvalid = 1'b0;
    jump   = 2'd0;
    jtarget = 26'd0;
    jreg   = 32'd0;

    tbl.push_back(mk(0,0,0,0,32'h00,0,0,0));
    tbl.push_back(mk(0,0,0,0,32'h04,0,0,0));
    tbl.push_back(mk(0,0,0,0,32'h08,0,0,0));
    tbl.push_back(mk(0,0,0,0,32'h0C,0,0,0));
    tbl.push_back(mk(0,0,0,0,32'h10,0,0,0));
    tbl.push_back(mk(0,0,0,0,32'h14,0,0,0));
    tbl.push_back(mk(0,0,0,0,32'h18,0,0,0));
    tbl.push_back(mk(0,0,0,0,32'h1C,0,0,0));
    tbl.push_back(mk(1,1,3,26'h100,32'h20,0,1,0));
    tbl.push_back(mk(1,1,3,26'h100,32'h20,0,0,1));
    tbl.push_back(mk(1,0,0,0,32'h20,0,0,1));
    tbl.push_back(mk(0,0,0,0,32'h20,0,0,1));
    tbl.push_back(mk(0,0,0,0,32'h400,1,0,1));
    tbl.push_back(mk(0,0,0,0,32'h404,1,0,1));
    tbl.push_back(mk(0,0,0,0,32'h408,1,0,1));
    tbl.push_back(mk(0,1,1,26'h4,32'h40C,0,0,0));
    tbl.push_back(mk(0,0,0,0,32'h10,1,0,1));
    tbl.push_back(mk(0,0,0,0,32'h14,1,0,1));
    tbl.push_back(mk(0,0,0,0,32'h18,1,0,1));
    tbl.push_back(mk(0,0,0,0,32'h1C,0,0,0));

    repeat (2) tick();
    chk("rst pc", pc, 32'h0);
    chk("rst flush", {31'd0, flush}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst exc", {31'd0, exc_misalign}, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].s, tbl[i].v, tbl[i].j,
            tbl[i].jt, tbl[i].jr);
      chk($sformatf("tbl%0d pc", i), pc, tbl[i].pc);
      chk($sformatf("tbl%0d flush", i),
          {31'd0, flush}, {31'd0, tbl[i].fl});
      chk($sformatf("tbl%0d link_we", i),
          {31'd0, link_we}, {31'd0, tbl[i].lw});
      chk($sformatf("tbl%0d busy", i),
          {31'd0, busy}, {31'd0, tbl[i].bz});
      chk($sformatf("tbl%0d link_addr", i),
          link_addr, tbl[i].pc + 32'd4);
      tick();
    end

    // Long jump into a new region, then J inside it
    drive(0, 1, 2'd2, 26'd0, 32'h1000_0000);
    tick();
    repeat (FC + 1) begin
      idle();
      tick();
    end
    drive(0, 1, 2'd1, 26'h40, 32'd0);
    chk("j pc0", pc, 32'h1000_0010);
    tick();
    idle();
    chk("j tgt", pc, 32'h1000_0100);
    chk("j flush", {31'd0, flush}, 32'd1);
    tick();
    chk("j next", pc, 32'h1000_0104);
    repeat (FC - 1) tick();
    chk("j done pc", pc, 32'h1000_010C);
    chk("j done flush", {31'd0, flush}, 32'd0);

    // Stalls inside FLUSH stretch it; JR ignored
    drive(0, 1, 2'd1, 26'h200, 32'd0);
    tick();
    sp  = 8'b0000_0110;
    nfl = 0;
    for (int k = 0; k < 8; k++) begin
      drive(sp[k], (k < 5), 2'd2, 26'd0,
            32'h0000_5000);
      if (flush) nfl++;
      tick();
    end
    chk("stretch count", nfl, 5);
    chk("stretch pc", pc, 32'h1000_0818);
    chk("stretch busy", {31'd0, busy}, 32'd0);

    // Wrap of pc+4 at the top of memory
    drive(0, 1, 2'd2, 26'd0, 32'hFFFF_FFFC);
    tick();
    idle();
    chk("wrap pc", pc, 32'hFFFF_FFFC);
    chk("wrap plus4", pc_plus4, 32'h0);
    tick();
    chk("wrap next", pc, 32'h0);
    repeat (4) tick();

    // Misaligned JR
    drive(0, 1, 2'd2, 26'd0, 32'h0000_0102);
    chk("mis pre exc", {31'd0, exc_misalign}, 32'd0);
    tick();
    idle();
`ifdef JR_ALIGN_CHECK_EN
    chk("mis pc", pc, 32'h180);
    chk("mis exc", {31'd0, exc_misalign}, 32'd1);
`else
    chk("mis pc", pc, 32'h100);
    chk("mis exc", {31'd0, exc_misalign}, 32'd0);
`endif
    tick();
    chk("mis exc end", {31'd0, exc_misalign}, 32'd0);
    repeat (4) tick();

    // Reset during HOLD drops the pending target
    drive(1, 1, 2'd2, 26'd0, 32'h0000_0400);
    tick();
    drive(1, 0, 2'd0, 26'd0, 32'd0);
    chk("hold busy", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst pc", pc, 32'h0);
    chk("arst busy", {31'd0, busy}, 32'd0);
    chk("arst flush", {31'd0, flush}, 32'd0);
    #1 rst_n = 1'b1;
    stall = 1'b0;
    tick();
    idle();
    chk("post rst pc", pc, 32'h4);
    chk("post rst busy", {31'd0, busy}, 32'd0);
    tick();
    chk("post rst pc2", pc, 32'h8);

    // Random traffic against the model
    rst_n = 1'b0;
    tick();
    rst_n  = 1'b1;
    m_pc   = 32'h0;
    m_hold = 1'b0;
    m_tgt  = 32'h0;
    m_left = 0;
    m_exc  = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 9) < 3),
            ($urandom_range(0, 9) < 3),
            2'($urandom_range(0, 3)),
            26'($urandom),
            (($urandom_range(0, 15) == 0)
              ? 32'hFFFF_FFFC : $urandom));
      acc = !m_hold && (m_left == 0) && jvalid
         && (jump != 2'd0);
      chk("rnd pc", pc, m_pc);
      chk("rnd plus4", pc_plus4, m_pc + 32'd4);
      chk("rnd link_addr", link_addr,
          m_pc + 32'd4);
      chk("rnd flush", {31'd0, flush},
          {31'd0, (m_left > 0)});
      chk("rnd busy", {31'd0, busy},
          {31'd0, (m_hold || m_left > 0)});
      chk("rnd link_we", {31'd0, link_we},
          {31'd0, (acc && jump == 2'd3)});
      chk("rnd exc", {31'd0, exc_misalign},
          {31'd0, m_exc});
      t = ref_target(m_pc, jump, jtarget, jreg);
`ifdef JR_ALIGN_CHECK_EN
      mis = acc && (jump == 2'd2)
         && (jreg % 4 != 0);
`else
      mis = 1'b0;
`endif
      m_exc = mis;
      if (m_hold) begin
        if (!stall) begin
          m_pc   = m_tgt;
          m_hold = 1'b0;
          m_left = FC;
        end
      end else if (m_left > 0) begin
        if (!stall) begin
          m_pc   = m_pc + 32'd4;
          m_left = m_left - 1;
        end
      end else if (acc) begin
        if (stall) begin
          m_hold = 1'b1;
          m_tgt  = t;
        end else begin
          m_pc   = t;
          m_left = FC;
        end
      end else if (!stall) begin
        m_pc = m_pc + 32'd4;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000: PC value after reset.
REQ-002 Parameter EXC_VECTOR, default 32'h0000_0180: target used for a misaligned jump-register.
REQ-003 Parameter FLUSH_CYCLES, default 1, range 1..7: non-stalled cycles that flush stays high after a redirect.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 stall  in  1  freezes PC advance while high.
REQ-007 jvalid  in  1  qualifies jump for the current cycle.
REQ-008 jump  in  2  0=none, 1=J, 2=JR, 3=JAL.
REQ-009 jtarget  in  26  instruction-index field.
REQ-010 jreg  in  32  register target for JR.
REQ-011 pc  out  32  current fetch address, registered.
REQ-012 pc_plus4  out  32  pc+4, combinational, modulo 2^32.
REQ-013 flush  out  1  kill younger instructions, Moore output of the FSM.
REQ-014 link_we  out  1  write-enable for the JAL return address.
REQ-015 link_addr  out  32  return address, equal to pc_plus4.
REQ-016 exc_misalign  out  1  registered one-cycle pulse.
REQ-017 busy  out  1  high in states HOLD and FLUSH.

Function
REQ-018 FSM states SHALL be RUN, HOLD and FLUSH; the reset state is RUN.
REQ-019 Target for J and JAL SHALL be {pc_plus4[31:28], jtarget, 2'b00}; the target for JR SHALL be jreg.
REQ-020 A jump is accepted only in RUN with jvalid=1 and jump!=0; jvalid/jump SHALL be ignored in HOLD and FLUSH.
REQ-021 RUN, stall=0, no accepted jump: pc<=pc_plus4 (0xFFFF_FFFC wraps to 0).
REQ-022 RUN, stall=0, accepted jump: pc<=target, flush counter<=FLUSH_CYCLES, state->FLUSH.
REQ-023 RUN, stall=1: pc holds; if a jump is accepted, target is latched into the pending register and state->HOLD.
REQ-024 HOLD: pc holds while stall=1; when stall=0, pc<=pending, counter<=FLUSH_CYCLES, state->FLUSH.
REQ-025 FLUSH: flush=1; each cycle with stall=0, pc<=pc_plus4 and the counter decrements; stall=1 freezes pc and the counter; counter reaching 0 -> RUN.
REQ-026 The cycle after FLUSH exits SHALL accept a new jump normally, with no dead cycle.
REQ-027 link_we SHALL be combinational, high exactly in the accepting cycle of a JAL, including under stall; it is never repeated from HOLD.
REQ-028 flush SHALL be high for exactly FLUSH_CYCLES non-stalled cycles per redirect.

Reset
REQ-029 rst_n low SHALL asynchronously force pc=RESET_VECTOR, state=RUN, flush=0, exc_misalign=0, busy=0, counter=0 and pending cleared.
REQ-030 Reset mid-HOLD or mid-FLUSH SHALL discard the pending redirect; the first cycle after release fetches RESET_VECTOR+4.

Configuration
REQ-031 With JR_ALIGN_CHECK_EN defined, a JR with jreg[1:0]!=0 SHALL use EXC_VECTOR as target and pulse exc_misalign one cycle after acceptance.
REQ-032 Without JR_ALIGN_CHECK_EN, the JR target SHALL be {jreg[31:2], 2'b00} and exc_misalign SHALL be tied 0; the port exists in both builds.

Structure
REQ-033 Package pc_seq_pkg SHALL hold the jump encoding enum, the FSM state enum and the default vector constants.
REQ-034 Target selection SHALL be a combinational sub-module, jump_target_calc; the FSM, counter, pending register and PC register live in pc_sequencer.

Verification
REQ-035 Reset release, stall=0 for 3 cycles -> pc 0x0, 0x4, 0x8, 0xC; flush=0.
REQ-036 pc=0x1000_0010, J with jtarget=26'h000_0040 -> next pc 0x1000_0100; flush=1 for 1 cycle; then pc 0x1000_0104.
REQ-037 stall=1 and JAL accepted at pc=0x20 -> link_we=1, link_addr=0x24 that cycle; pc holds through 3 stalled cycles; stall drop -> pc=target, flush=1.
REQ-038 FLUSH_CYCLES=3, stall=1 for 2 cycles inside FLUSH, JR issued during FLUSH -> flush high for 5 cycles total; the JR is ignored.
REQ-039 JR_ALIGN_CHECK_EN defined, JR jreg=0x0000_0102 -> pc=0x180, exc_misalign pulse; macro undefined -> pc=0x100, exc_misalign=0.
REQ-040 rst_n asserted in HOLD with pending=0x400 -> pc=0x0 immediately; the pending redirect is never applied.
